mainfsm_param: RTL and testbench
================================

Name: mainfsm_param

Overview:
- Parametrised next-generation main control FSM for the multicycle ARM-subset core. It sequences fetch, decode, data-processing, memory and branch instructions.
- New relative to the current FSM:
  - optional memory-ready handshake that stalls on slow memory;
  - a multi-cycle multiply path with a programmable latency;
  - an illegal-instruction flag.
- Sits in the controller beside the ALU decoder and condition logic, and drives the datapath mux selects and write enables.

Parameters:
- USE_MEMREADY, 0: 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady=1; 0 = MemReady is ignored and memory states take 1 cycle.
- MUL_CYCLES, 4: number of cycles spent in MULEXEC (legal range 1..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- Op  input  2  instruction op field
- Funct  input  6  instruction funct field
- IsMul  input  1  decoded multiply instruction (valid with Op=00)
- MemReady  input  1  memory completed the current access
- IRWrite  output  1  instruction register write enable
- AdrSrc  output  1  memory address select (0 = PC, 1 = ALU result)
- ALUSrcA  output  2  ALU A select
- ALUSrcB  output  2  ALU B select
- ResultSrc  output  2  result mux select (00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = MulResult)
- NextPC  output  1  PC update enable
- RegW  output  1  register write enable
- MemW  output  1  memory write enable
- Branch  output  1  branch enable
- ALUOp  output  1  ALU decoder enable
- MemReq  output  1  memory access request
- MulStart  output  1  one-cycle start pulse for the multiplier
- Illegal  output  1  one-cycle pulse on an undefined op
- State  output  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10, MULEXEC=11, MULWB=12.
- Reset: the async reset forces state to FETCH and the multiply counter to 0. Outputs are combinational from state, so immediately after reset they show FETCH values.
- Define "done" as (MemReady | ~USE_MEMREADY).
- Transitions:
  - FETCH -> DECODE when done, else stay in FETCH.
  - DECODE, Op=00:
    - IsMul -> MULEXEC;
    - else Funct[5]=1 -> EXECUTEI;
    - else -> EXECUTER.
  - DECODE, Op=01 -> MEMADR.
  - DECODE, Op=10 -> BRANCH.
  - DECODE, Op=11 -> UNKNOWN.
  - EXECUTER and EXECUTEI -> ALUWB.
  - MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB when done, else stay.
  - MEMWRITE -> FETCH when done, else stay.
  - MULEXEC: stay until the counter reaches MUL_CYCLES-1, then -> MULWB.
  - ALUWB, MEMWB, BRANCH, MULWB, UNKNOWN -> FETCH.
  - Encodings 13..15 -> FETCH.
- Multiply counter: cleared on entry to MULEXEC and incremented each MULEXEC cycle. With MUL_CYCLES=1, MULEXEC lasts exactly one cycle.
- Outputs per state: any field not listed is 0 (no X values anywhere).
  - FETCH: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC equal done, so they pulse only in the completing cycle.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1, ResultSrc=00.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: MemReq=1, AdrSrc=1.
  - MEMWRITE: MemReq=1, AdrSrc=1, MemW=1. MemW is held for the whole stall.
  - MEMWB: RegW=1, ResultSrc=01.
  - BRANCH: Branch=1, ALUSrcB=01, ResultSrc=10.
  - MULEXEC: MulStart=1 only in its first cycle (counter=0).
  - MULWB: RegW=1, ResultSrc=11.
  - UNKNOWN: Illegal=1.
- Boundary conditions:
  - MemReady asserted outside memory states has no effect.
  - Reset asserted mid-stall or mid-multiply aborts the instruction with no RegW/MemW after the reset edge.
  - Op, Funct and IsMul are sampled only in DECODE and MEMADR.

Test Plan:
1. USE_MEMREADY=0, ADD register (Op=00, Funct=000000) -> states 0,1,6,8,0; ALUOp=1 in EXECUTER; RegW=1 only in ALUWB; 4 cycles total.
2. USE_MEMREADY=1, LDR (Op=01, Funct[0]=1), MemReady low for 3 cycles in FETCH and 2 in MEMREAD -> IRWrite/NextPC pulse once, in the 4th FETCH cycle; MEMWB follows the 3rd MEMREAD cycle; ResultSrc=01 with RegW=1.
3. STR (Funct[0]=0), MemReady=0 for 2 cycles -> MemW=1 for 3 cycles; return to FETCH; RegW never asserted.
4. MUL_CYCLES=4, IsMul=1 -> MULEXEC for 4 cycles; MulStart is high in the first only; MULWB asserts RegW=1 with ResultSrc=11. Repeat with MUL_CYCLES=1 -> 1 cycle.
5. Op=11 -> UNKNOWN with Illegal=1 for exactly 1 cycle, then FETCH. Op=10 -> BRANCH with Branch=1, ALUSrcB=01.
6. Reset asserted in cycle 2 of MULEXEC and again in a MEMWRITE stall -> State=0 asynchronously; MemW, RegW and MulStart low after reset; normal fetch resumes after deassertion.

Source files
------------

// File: rtl/mainfsm_param.sv
// Main control FSM for the multicycle ARM-subset core: sequences fetch/decode/execute,
// with optional memory-ready stalls, a multi-cycle multiply path and an illegal-op flag.
module mainfsm_param #(
    parameter int unsigned USE_MEMREADY = 0,
    parameter int unsigned MUL_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       IsMul,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       MemReq,
    output logic       MulStart,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned CNT_W  = 4;
    localparam logic        USE_MR = logic'(USE_MEMREADY != 0);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10,
        S_MULEXEC  = 4'd11,
        S_MULWB    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_mul_cnt;
    logic             w_done;
    logic             w_unused;

    // Memory access completes immediately when the handshake is disabled
    assign w_done   = MemReady | ~USE_MR;
    assign w_unused = ^Funct[4:1];
    assign State    = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter idles at zero outside MULEXEC, so it is clear on every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_cnt <= '0;
        end else if (r_state == S_MULEXEC) begin
            r_mul_cnt <= r_mul_cnt + CNT_W'(1);
        end else begin
            r_mul_cnt <= '0;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00: begin
                        if (IsMul)         w_next = S_MULEXEC;
                        else if (Funct[5]) w_next = S_EXECUTEI;
                        else               w_next = S_EXECUTER;
                    end
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_done ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_done ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_MULEXEC:  w_next = (r_mul_cnt == MUL_LAST) ? S_MULWB : S_MULEXEC;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        MemReq    = 1'b0;
        MulStart  = 1'b0;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_done;
                NextPC    = w_done;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  RegW = 1'b1;
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
            end
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            S_MULEXEC: MulStart = (r_mul_cnt == '0);
            S_MULWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b11;
            end
            S_UNKNOWN: Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mainfsm_param.sv
// Scoreboard bench for mainfsm_param: three parameter variants share stimulus,
// one is selected per test and compared cycle by cycle against hand-computed vectors.
module tb_mainfsm_param;

    typedef struct packed {
        logic [3:0] state;
        logic       irw;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       npc;
        logic       regw;
        logic       memw;
        logic       br;
        logic       aluop;
        logic       memreq;
        logic       mulst;
        logic       ill;
    } obs_t;

    localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3;
    localparam logic [3:0] MB = 4'd4,  MW = 4'd5,  ER = 4'd6,  EI = 4'd7;
    localparam logic [3:0] AW = 4'd8,  BR = 4'd9,  UN = 4'd10, MX = 4'd11;
    localparam logic [3:0] XW = 4'd12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       IsMul = 1'b0;
    logic       MemReady = 1'b0;

    always #5 clk = ~clk;

    // Instance A: no handshake, MUL_CYCLES=4
    logic a_irw, a_adr, a_npc, a_regw, a_memw, a_br, a_aluop, a_memreq, a_mulst, a_ill;
    logic [1:0] a_srca, a_srcb, a_res;
    logic [3:0] a_state;
    mainfsm_param #(.USE_MEMREADY(0), .MUL_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
        .IRWrite(a_irw), .AdrSrc(a_adr), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ResultSrc(a_res),
        .NextPC(a_npc), .RegW(a_regw), .MemW(a_memw), .Branch(a_br), .ALUOp(a_aluop),
        .MemReq(a_memreq), .MulStart(a_mulst), .Illegal(a_ill), .State(a_state)
    );

    // Instance B: memory handshake enabled
    logic b_irw, b_adr, b_npc, b_regw, b_memw, b_br, b_aluop, b_memreq, b_mulst, b_ill;
    logic [1:0] b_srca, b_srcb, b_res;
    logic [3:0] b_state;
    mainfsm_param #(.USE_MEMREADY(1), .MUL_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
        .IRWrite(b_irw), .AdrSrc(b_adr), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ResultSrc(b_res),
        .NextPC(b_npc), .RegW(b_regw), .MemW(b_memw), .Branch(b_br), .ALUOp(b_aluop),
        .MemReq(b_memreq), .MulStart(b_mulst), .Illegal(b_ill), .State(b_state)
    );

    // Instance C: single-cycle multiply
    logic c_irw, c_adr, c_npc, c_regw, c_memw, c_br, c_aluop, c_memreq, c_mulst, c_ill;
    logic [1:0] c_srca, c_srcb, c_res;
    logic [3:0] c_state;
    mainfsm_param #(.USE_MEMREADY(0), .MUL_CYCLES(1)) u_c (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul), .MemReady(MemReady),
        .IRWrite(c_irw), .AdrSrc(c_adr), .ALUSrcA(c_srca), .ALUSrcB(c_srcb), .ResultSrc(c_res),
        .NextPC(c_npc), .RegW(c_regw), .MemW(c_memw), .Branch(c_br), .ALUOp(c_aluop),
        .MemReq(c_memreq), .MulStart(c_mulst), .Illegal(c_ill), .State(c_state)
    );

    obs_t obs_a, obs_b, obs_c, obs_sel;
    int   sel = 0;

    assign obs_a = {a_state, a_irw, a_adr, a_srca, a_srcb, a_res, a_npc, a_regw, a_memw,
                    a_br, a_aluop, a_memreq, a_mulst, a_ill};
    assign obs_b = {b_state, b_irw, b_adr, b_srca, b_srcb, b_res, b_npc, b_regw, b_memw,
                    b_br, b_aluop, b_memreq, b_mulst, b_ill};
    assign obs_c = {c_state, c_irw, c_adr, c_srca, c_srcb, c_res, c_npc, c_regw, c_memw,
                    c_br, c_aluop, c_memreq, c_mulst, c_ill};

    always_comb begin
        case (sel)
            1:       obs_sel = obs_b;
            2:       obs_sel = obs_c;
            default: obs_sel = obs_a;
        endcase
    end

    obs_t exp_q[$];
    int   id_q[$];
    int   step_id = 0;
    int   checks = 0;
    int   errors = 0;

    // Hand-written per-state output table; irw/ms carry the cycle-dependent bits
    function automatic obs_t exp_outs(input logic [3:0] st, input logic irw, input logic ms);
        obs_t o;
        o = '0;
        o.state = st;
        case (st)
            FE: begin o.memreq = 1; o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10;
                      o.irw = irw; o.npc = irw; end
            DE: begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
            MA: o.srcb = 2'b01;
            MR: begin o.memreq = 1; o.adr = 1; end
            MB: begin o.regw = 1; o.res = 2'b01; end
            MW: begin o.memreq = 1; o.adr = 1; o.memw = 1; end
            ER: o.aluop = 1;
            EI: begin o.srcb = 2'b01; o.aluop = 1; end
            AW: o.regw = 1;
            BR: begin o.br = 1; o.srcb = 2'b01; o.res = 2'b10; end
            UN: o.ill = 1;
            MX: o.mulst = ms;
            XW: begin o.regw = 1; o.res = 2'b11; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push_exp(input logic [3:0] st, input logic irw, input logic ms);
        exp_q.push_back(exp_outs(st, irw, ms));
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Asserts reset mid-cycle (async) and expects FETCH outputs immediately
    task automatic do_reset(input int s, input logic irw);
        @(posedge clk);
        #1;
        sel      = s;
        reset    = 1'b1;
        Op       = 2'b00;
        Funct    = 6'd0;
        IsMul    = 1'b0;
        MemReady = 1'b0;
        push_exp(FE, irw, 1'b0);
    endtask

    task automatic step(input logic [3:0] st, input logic irw, input logic ms,
                        input logic [1:0] op, input logic [5:0] fn,
                        input logic mul, input logic mr);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        Op       = op;
        Funct    = fn;
        IsMul    = mul;
        MemReady = mr;
        push_exp(st, irw, ms);
    endtask

    // Monitor: one expected vector per presented cycle
    initial begin
        obs_t e;
        int   id;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                checks++;
                if (obs_sel !== e) begin
                    errors++;
                    $display("FAIL step %0d (dut %0d): got state=%0d outs=%h, expected state=%0d outs=%h",
                             id, sel, obs_sel.state, obs_sel, e.state, e);
                end
            end
        end
    end

    initial begin
        // ADD reg then ADD imm, no handshake; Op change in EXECUTER ignored
        do_reset(0, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b000000, 0, 1);
        step(ER, 0, 0, 2'b11, 6'b100000, 1, 0);
        step(AW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b100000, 0, 0);
        step(EI, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(AW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);

        // LDR with FETCH and MEMREAD stalls
        do_reset(1, 1'b0);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 1);
        step(DE, 0, 0, 2'b01, 6'b000001, 0, 1);
        step(MA, 0, 0, 2'b01, 6'b000001, 0, 0);
        step(MR, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MR, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MR, 0, 0, 2'b00, 6'b000000, 0, 1);
        step(MB, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);

        // STR with two-cycle MEMWRITE stall
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 1);
        step(DE, 0, 0, 2'b01, 6'b000000, 0, 0);
        step(MA, 0, 0, 2'b01, 6'b000000, 0, 0);
        step(MW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MW, 0, 0, 2'b00, 6'b000000, 0, 1);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);

        // Two back-to-back 4-cycle multiplies; inputs toggled in MULEXEC ignored
        do_reset(0, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b000000, 1, 0);
        step(MX, 0, 1, 2'b11, 6'b000001, 0, 0);
        step(MX, 0, 0, 2'b01, 6'b000000, 1, 1);
        step(MX, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MX, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(XW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b100000, 1, 0);
        step(MX, 0, 1, 2'b00, 6'b000000, 0, 0);
        step(MX, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MX, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(MX, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(XW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);

        // Single-cycle multiply
        do_reset(2, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b000000, 1, 0);
        step(MX, 0, 1, 2'b00, 6'b000000, 0, 0);
        step(XW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);

        // Undefined op then branch
        do_reset(0, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b11, 6'b000000, 0, 0);
        step(UN, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b10, 6'b000000, 0, 0);
        step(BR, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);

        // Reset during the second MULEXEC cycle, then a normal ADD
        do_reset(0, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b000000, 1, 0);
        step(MX, 0, 1, 2'b00, 6'b000000, 0, 0);
        do_reset(0, 1'b1);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);
        step(DE, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(ER, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(AW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 0);

        // Reset during a MEMWRITE stall, then a normal ADD
        do_reset(1, 1'b0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 1);
        step(DE, 0, 0, 2'b01, 6'b000000, 0, 0);
        step(MA, 0, 0, 2'b01, 6'b000000, 0, 0);
        step(MW, 0, 0, 2'b00, 6'b000000, 0, 0);
        do_reset(1, 1'b0);
        step(FE, 1, 0, 2'b00, 6'b000000, 0, 1);
        step(DE, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(ER, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(AW, 0, 0, 2'b00, 6'b000000, 0, 0);
        step(FE, 0, 0, 2'b00, 6'b000000, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
